// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, voice event struct and allocator FSM states.
package synth_pkg;
    localparam int NOTE_W         = 4;
    localparam int OCT_W          = 3;
    localparam int DEFAULT_OCTAVE = 4;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
    } voice_ev_t;

    typedef enum logic {IDLE, PROC} state_t;
endpackage

// File: rtl/voice_lru.sv
// voice_lru: LRU age permutation over voice slots; reports the oldest slot.
module voice_lru
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    localparam int IW = $clog2(NUM_VOICES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_idx,
    output logic [IW-1:0] oldest_idx
);
    logic [IW-1:0] r_age [NUM_VOICES];

    // Slots younger than the chosen one age by one; the chosen slot becomes 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= IW'(v);
        end else if (alloc_valid) begin
            for (int v = 0; v < NUM_VOICES; v++)
                r_age[v] <= (IW'(v) == alloc_idx) ? '0 :
                            (r_age[v] < r_age[alloc_idx]) ? r_age[v] + 1'b1 : r_age[v];
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (r_age[v] == IW'(NUM_VOICES - 1)) oldest_idx = IW'(v);
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice scheduler (retrigger, free, steal-oldest).
// Optional VOICE_ALLOC_STEAL_CNT_EN adds an 8-bit saturating steal counter port.
module voice_allocator #(
    parameter int NUM_VOICES     = 4,
    parameter int NOTE_W         = synth_pkg::NOTE_W,
    parameter int OCT_W          = synth_pkg::OCT_W,
    parameter int DEFAULT_OCTAVE = synth_pkg::DEFAULT_OCTAVE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [OCT_W-1:0]             ev_octave,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*OCT_W-1:0]  voice_octave,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         busy
`ifdef VOICE_ALLOC_STEAL_CNT_EN
    ,output logic [7:0]                  steal_cnt
`endif
);
    import synth_pkg::*;

    localparam int IW = $clog2(NUM_VOICES);

    state_t                             r_state;
    logic                               r_ready;
    logic                               r_busy;
    logic                               r_on;
    logic [NOTE_W-1:0]                  r_note;
    logic [OCT_W-1:0]                   r_oct;
    logic [NUM_VOICES-1:0]              r_gate;
    logic [NUM_VOICES-1:0]              r_trig;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]  r_vnote;
    logic [NUM_VOICES-1:0][OCT_W-1:0]   r_voct;

    logic                               w_hit;
    logic                               w_free_any;
    logic [IW-1:0]                      w_match_idx;
    logic [IW-1:0]                      w_free_idx;
    logic [IW-1:0]                      w_oldest;
    logic [IW-1:0]                      w_sel_idx;
    logic                               w_alloc;

    // Descending scan leaves the lowest-index free slot selected.
    always_comb begin
        w_hit       = 1'b0;
        w_free_any  = 1'b0;
        w_match_idx = '0;
        w_free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_gate[v] && r_vnote[v] == r_note && r_voct[v] == r_oct) begin
                w_hit       = 1'b1;
                w_match_idx = IW'(v);
            end
            if (!r_gate[v]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(v);
            end
        end
    end

    assign w_sel_idx = w_hit ? w_match_idx : w_free_any ? w_free_idx : w_oldest;
    assign w_alloc   = (r_state == PROC) && r_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_on    <= 1'b0;
            r_note  <= '0;
            r_oct   <= '0;
            r_gate  <= '0;
            r_trig  <= '0;
            r_vnote <= '0;
            r_voct  <= {NUM_VOICES{OCT_W'(DEFAULT_OCTAVE)}};
        end else begin
            r_trig <= '0;
            if (r_state == IDLE) begin
                if (ev_valid) begin
                    r_on    <= ev_on;
                    r_note  <= ev_note;
                    r_oct   <= ev_octave;
                    r_state <= PROC;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
            end else begin
                r_state <= IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                if (r_on) begin
                    r_gate[w_sel_idx]  <= 1'b1;
                    r_trig[w_sel_idx]  <= 1'b1;
                    r_vnote[w_sel_idx] <= r_note;
                    r_voct[w_sel_idx]  <= r_oct;
                end else if (w_hit) begin
                    r_gate[w_match_idx] <= 1'b0;
                end
            end
        end
    end

    voice_lru #(.NUM_VOICES(NUM_VOICES)) u_lru (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (w_alloc),
        .alloc_idx   (w_sel_idx),
        .oldest_idx  (w_oldest)
    );

`ifdef VOICE_ALLOC_STEAL_CNT_EN
    logic       w_steal;
    logic [7:0] r_steal_cnt;
    assign w_steal = w_alloc && !w_hit && !w_free_any;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_steal_cnt <= '0;
        else if (w_steal && r_steal_cnt != 8'hFF) r_steal_cnt <= r_steal_cnt + 1'b1;
    end
    assign steal_cnt = r_steal_cnt;
`endif

    assign ev_ready     = r_ready;
    assign busy         = r_busy;
    assign voice_gate   = r_gate;
    assign voice_trig   = r_trig;
    assign voice_note   = r_vnote;
    assign voice_octave = r_voct;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed + random events against an LRU-list reference model.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   ev_valid = 1'b0;
    logic                   ev_on = 1'b0;
    logic [NOTE_W-1:0]      ev_note = '0;
    logic [OCT_W-1:0]       ev_octave = '0;
    logic                   ev_ready;
    logic                   busy;
    logic [NV-1:0]          voice_gate;
    logic [NV-1:0]          voice_trig;
    logic [NV*NOTE_W-1:0]   voice_note;
    logic [NV*OCT_W-1:0]    voice_octave;
`ifdef VOICE_ALLOC_STEAL_CNT_EN
    logic [7:0]             steal_cnt;
`endif

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_octave    (ev_octave),
        .voice_gate   (voice_gate),
        .voice_note   (voice_note),
        .voice_octave (voice_octave),
        .voice_trig   (voice_trig),
        .busy         (busy)
`ifdef VOICE_ALLOC_STEAL_CNT_EN
        ,.steal_cnt   (steal_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: slot contents plus an LRU list (front = youngest).
    int m_gate [NV];
    int m_note [NV];
    int m_oct  [NV];
    int lru [$];
    int m_trig;
    int m_steal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        lru = {};
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 0;
            m_note[v] = 0;
            m_oct[v]  = DEFAULT_OCTAVE;
            lru.push_back(v);
        end
        m_trig  = -1;
        m_steal = 0;
    endfunction

    function automatic void m_event(input voice_ev_t e);
        int s = -1;
        int pos = 0;
        m_trig = -1;
        for (int v = 0; v < NV; v++)
            if (m_gate[v] != 0 && m_note[v] == int'(e.note) && m_oct[v] == int'(e.octave)) s = v;
        if (e.on) begin
            for (int v = 0; v < NV; v++)
                if (s < 0 && m_gate[v] == 0) s = v;
            if (s < 0) begin
                s = lru[$];
                m_steal = (m_steal < 255) ? m_steal + 1 : 255;
            end
            m_gate[s] = 1;
            m_note[s] = int'(e.note);
            m_oct[s]  = int'(e.octave);
            m_trig    = s;
            foreach (lru[i]) if (lru[i] == s) pos = i;
            lru.delete(pos);
            lru.push_front(s);
        end else if (s >= 0) begin
            m_gate[s] = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [NV-1:0]        eg = '0;
        logic [NV-1:0]        et = '0;
        logic [NV*NOTE_W-1:0] en = '0;
        logic [NV*OCT_W-1:0]  eo = '0;
        for (int v = 0; v < NV; v++) begin
            eg[v] = (m_gate[v] != 0);
            et[v] = (m_trig == v);
            en[v*NOTE_W +: NOTE_W] = NOTE_W'(m_note[v]);
            eo[v*OCT_W +: OCT_W]   = OCT_W'(m_oct[v]);
        end
        chk({tag, "_gate"}, 32'(voice_gate), 32'(eg));
        chk({tag, "_trig"}, 32'(voice_trig), 32'(et));
        chk({tag, "_note"}, 32'(voice_note), 32'(en));
        chk({tag, "_oct"}, 32'(voice_octave), 32'(eo));
        chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef VOICE_ALLOC_STEAL_CNT_EN
        chk({tag, "_steal_cnt"}, 32'(steal_cnt), 32'(m_steal));
`endif
    endtask

    // Called just after a negedge; returns just after the negedge following PROC exit.
    task automatic send(input logic on, input int note, input int oct, input bit keep);
        int n = 0;
        voice_ev_t e;
        e = '{on: on, note: NOTE_W'(note), octave: OCT_W'(oct)};
        ev_valid = 1'b1; ev_on = on; ev_note = e.note; ev_octave = e.octave;
        while (!ev_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(ev_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) ev_valid = 1'b0;
        @(negedge clk);
        chk("proc_ready", 32'(ev_ready), 32'd0);
        chk("proc_busy", 32'(busy), 32'd1);
        chk("trig_width", 32'(voice_trig), 32'd0);
        @(posedge clk);
        m_event(e);
        @(negedge clk);
        check_all("ev");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        send(1'b1, 0, 4, 1'b0);
        chk("c4_gate", 32'(voice_gate), 32'h1);
        chk("c4_trig", 32'(voice_trig), 32'h1);

        send(1'b1, 2, 4, 1'b0);
        send(1'b1, 4, 4, 1'b0);
        send(1'b1, 5, 4, 1'b0);
        chk("full_gate", 32'(voice_gate), 32'hF);
        send(1'b1, 7, 4, 1'b0);
        chk("steal_note0", 32'(voice_note[NOTE_W-1:0]), 32'd7);
        chk("steal_trig", 32'(voice_trig), 32'h1);

        send(1'b1, 2, 4, 1'b0);
        chk("retrig_trig", 32'(voice_trig), 32'h2);
        chk("retrig_gate", 32'(voice_gate), 32'hF);

        send(1'b0, 5, 4, 1'b0);
        chk("off_gate", 32'(voice_gate), 32'h7);
        chk("off_note_kept", 32'(voice_note[3*NOTE_W +: NOTE_W]), 32'd5);
        send(1'b0, 9, 3, 1'b0);

        t0 = cyc;
        for (int i = 0; i < 6; i++) send(i % 3 != 2, (i * 5) % 16, 3 + (i % 2), 1'b1);
        ev_valid = 1'b0;
        chk("b2b_cycles", 32'(cyc - t0), 32'd12);

        // Reset while PROC holds an event: it must be discarded.
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd3; ev_octave = 3'd2;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_all("rst_proc");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("post_rst");
        for (int i = 0; i < 4; i++) send(1'b1, 10 + i, 1, 1'b0);
        send(1'b1, 15, 1, 1'b0);
        chk("lru_restored_trig", 32'(voice_trig), 32'h1);

        for (int i = 0; i < 60; i++)
            send($urandom_range(0, 2) != 0, int'($urandom_range(0, 5)), int'($urandom_range(3, 4)),
                 bit'($urandom_range(0, 1)));
        ev_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ev_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
